sysid_regs: RTL
===============

# sysid_regs

Parametrised system-identification and housekeeping register block on an Avalon-MM slave port. It generalises the fixed two-word ID/timestamp slave into an eight-word register map. The map holds build identity constants, a free-running 64-bit cycle counter with an atomic high-word snapshot, a seconds uptime counter and a software scratch register. The block sits on the system interconnect beside the CPU and gives firmware build and liveness information. Reads have a registered response with fixed latency 1.

## Interface
- SYS_ID, 32'h0000_0000, system identifier constant
- BUILD_TS, 32'd0, build timestamp (Unix seconds)
- VERSION, 32'h0001_0000, design version, major[31:16] minor[15:0]
- CLK_HZ, 50_000_000, clock frequency in Hz; legal range ≥1
- ADDR_W, 3, word-address width; legal range ≥3

- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- address  in  ADDR_W  word address
- read  in  1  read strobe, one transfer per cycle it is high
- write  in  1  write strobe
- writedata  in  32  write data
- readdata  out  32  registered read data
- readdatavalid  out  1  one-cycle pulse marking valid readdata

## Operation
Register map by word address:
- 0 ID (RO) = SYS_ID
- 1 TIMESTAMP (RO) = BUILD_TS
- 2 VERSION (RO) = VERSION
- 3 CLK_FREQ (RO) = CLK_HZ[31:0]
- 4 UPTIME (RO): 32-bit seconds counter
- 5 CYCLE_LO (RO): live low word of the cycle counter. The same read loads the shadow with the counter's high word.
- 6 CYCLE_HI (RO): shadow high word. It changes only on a CYCLE_LO read.
- 7 SCRATCH (RW): 32 bits, written by any write to address 7

Access rules:
- No waitrequest. Every read and write is accepted in the cycle it is asserted.
- Writes to addresses 0–6 are ignored.
- Addresses ≥8 (when ADDR_W>3) read 0 and ignore writes.

Counters:
- Cycle counter: 64 bits. Increments by 1 every clock while out of reset. Wraps from 2^64−1 to 0.
- Prescaler: counts 0..CLK_HZ−1. Width is clog2(CLK_HZ), minimum 1 bit.
- When the prescaler equals CLK_HZ−1, it returns to 0 and UPTIME increments by 1. UPTIME wraps from 2^32−1 to 0.
- With CLK_HZ=1, UPTIME increments every cycle.

## Timing
Reset values:
- readdata=0, readdatavalid=0
- cycle counter=0, shadow=0, prescaler=0, UPTIME=0, SCRATCH=0

Read timing:
- Read latency is exactly 1. With read high at edge N, readdata and readdatavalid=1 are valid after edge N.
- readdatavalid stays high for exactly one cycle per read.
- Back-to-back reads give back-to-back valid pulses.
- Between reads, readdata holds its last value.

Read values:
- A read returns register values as they were before the capturing edge. For counters, that is the pre-increment value.
- A CYCLE_LO read at edge N returns counter[31:0] before edge N. At the same edge, the shadow takes counter[63:32] of that same pre-edge value, so the pair is coherent.

Simultaneous and boundary cases:
- Simultaneous read and write to SCRATCH: readdata returns the old value, and the new value is stored at the same edge.
- Simultaneous read and write to different addresses: both take effect independently.
- Reset asserted mid-operation (any cycle) clears all state immediately, including a pending readdatavalid. The first read after reset deassertion behaves normally.

## Test plan
- Reset, then read addresses 0,1,2,3 back-to-back with SYS_ID=32'h5258_0001, BUILD_TS=1381543399, VERSION=32'h0002_0003, CLK_HZ=10 -> four consecutive readdatavalid pulses, each one cycle after its read, with data 32'h5258_0001, 1381543399, 32'h0002_0003, 10.
- Write 32'hDEAD_BEEF to address 7, then read 7 -> 32'hDEAD_BEEF. Same cycle: write 32'h1234_5678 and read 7 -> returns 32'hDEAD_BEEF; next read returns 32'h1234_5678. Writes to addresses 0 and 4 leave their reads unchanged.
- With CLK_HZ=10, read UPTIME at cycles 9, 10, 29 and 30 after reset release -> 0, 1, 2, 3. Confirms the edge-exact increment when the prescaler equals 9.
- Force the cycle counter to 64'h0000_0001_FFFF_FFFE. Read 5 at that cycle, then read 6 three cycles later -> 32'hFFFF_FFFE, then 32'h0000_0001. The shadow is unchanged by the low-word wrap.
- Assert reset_n low between a read strobe and its response edge -> readdatavalid stays 0, readdata=0, SCRATCH=0. After release, read 7 -> 0 with a valid pulse one cycle later.

Source files
------------

// File: rtl/sysid_regs.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sysid_regs : build-identity, cycle/uptime counters and scratch on Avalon-MM
// Revision   : 1.0
// ---------------------------------------------------------------------------
module sysid_regs #(
  parameter logic [31:0] SYS_ID   = 32'h0000_0000,
  parameter logic [31:0] BUILD_TS = 32'd0,
  parameter logic [31:0] VERSION  = 32'h0001_0000,
  parameter int unsigned CLK_HZ   = 50_000_000,
  parameter int unsigned ADDR_W   = 3
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              readdatavalid
);

  localparam int unsigned      PSC_W   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PSC_W-1:0] PSC_MAX = PSC_W'(CLK_HZ - 1);
  localparam logic [31:0]      CLK_FREQ_WORD = 32'(CLK_HZ);

  localparam logic [2:0] A_ID       = 3'd0;
  localparam logic [2:0] A_TS       = 3'd1;
  localparam logic [2:0] A_VERSION  = 3'd2;
  localparam logic [2:0] A_CLK_FREQ = 3'd3;
  localparam logic [2:0] A_UPTIME   = 3'd4;
  localparam logic [2:0] A_CYC_LO   = 3'd5;
  localparam logic [2:0] A_CYC_HI   = 3'd6;
  localparam logic [2:0] A_SCRATCH  = 3'd7;

  logic [63:0]      cycle_q,   cycle_d;
  logic [31:0]      shadow_q,  shadow_d;
  logic [PSC_W-1:0] presc_q,   presc_d;
  logic [31:0]      uptime_q,  uptime_d;
  logic [31:0]      scratch_q, scratch_d;
  logic [31:0]      readdata_q, readdata_d;
  logic             rvalid_q,  rvalid_d;

  logic       in_map;
  logic [2:0] reg_sel;
  logic [31:0] rd_mux;

  assign reg_sel = address[2:0];

  // Upper address bits only exist when the window is wider than the map.
  generate
    if (ADDR_W > 3) begin : g_hi_decode
      assign in_map = ~|address[ADDR_W-1:3];
    end else begin : g_no_hi_decode
      assign in_map = 1'b1;
    end
  endgenerate

  always_comb begin
    rd_mux = 32'd0;
    if (in_map) begin
      case (reg_sel)
        A_ID:       rd_mux = SYS_ID;
        A_TS:       rd_mux = BUILD_TS;
        A_VERSION:  rd_mux = VERSION;
        A_CLK_FREQ: rd_mux = CLK_FREQ_WORD;
        A_UPTIME:   rd_mux = uptime_q;
        A_CYC_LO:   rd_mux = cycle_q[31:0];
        A_CYC_HI:   rd_mux = shadow_q;
        A_SCRATCH:  rd_mux = scratch_q;
        default:    rd_mux = 32'd0;
      endcase
    end
  end

  always_comb begin
    cycle_d    = cycle_q + 64'd1;
    shadow_d   = shadow_q;
    presc_d    = presc_q + PSC_W'(1);
    uptime_d   = uptime_q;
    scratch_d  = scratch_q;
    readdata_d = readdata_q;
    rvalid_d   = read;

    if (presc_q == PSC_MAX) begin
      presc_d  = '0;
      uptime_d = uptime_q + 32'd1;
    end

    if (write && in_map && (reg_sel == A_SCRATCH)) begin
      scratch_d = writedata;
    end

    if (read) begin
      readdata_d = rd_mux;
      // Latch the high word from the same pre-edge count as the low word.
      if (in_map && (reg_sel == A_CYC_LO)) begin
        shadow_d = cycle_q[63:32];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cycle_q    <= 64'd0;
      shadow_q   <= 32'd0;
      presc_q    <= '0;
      uptime_q   <= 32'd0;
      scratch_q  <= 32'd0;
      readdata_q <= 32'd0;
      rvalid_q   <= 1'b0;
    end else begin
      cycle_q    <= cycle_d;
      shadow_q   <= shadow_d;
      presc_q    <= presc_d;
      uptime_q   <= uptime_d;
      scratch_q  <= scratch_d;
      readdata_q <= readdata_d;
      rvalid_q   <= rvalid_d;
    end
  end

  assign readdata      = readdata_q;
  assign readdatavalid = rvalid_q;

endmodule
`default_nettype wire
